// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: iterative unsigned multiply/divide unit for the EX stage.
// MUL/MULHU use 32 shift-add steps over a 64-bit product register.
// DIVU/REMU use 32 restoring shift-subtract steps. Both share the same register.
// Optional feature macro: MULDIV_DIV_EN. When it is defined, the divider is built.
// When it is undefined, ops 10/11 go to DONE in one cycle with result 0.
// Handshake: start is a request sampled on clk. It is accepted in IDLE or DONE
// when flush=0. It is ignored while RUN. done is a one-cycle pulse in DONE,
// and result is valid only while done=1.
module muldiv_sequencer (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        flush,
  output logic        busy,
  output logic        stall,
  output logic        done,
  output logic [31:0] result,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd2} state_t;

  state_t      r_state;
  logic [5:0]  r_cnt;
  logic [1:0]  r_op;
  logic [31:0] r_opa;
  logic [63:0] r_acc;
  logic        r_done;
  logic [31:0] r_result;

  logic        w_accept;
  logic [32:0] w_mul_sum;
  logic [63:0] w_mul_next;
  logic [63:0] w_step;
  logic [31:0] w_final;

  // A new request is taken whenever the unit is not iterating, unless squashed.
  assign w_accept  = ~reset & (r_state != S_RUN) & start & ~flush;
  assign stall     = ~reset & ((r_state == S_RUN) | w_accept);
  assign busy      = (r_state == S_RUN);
  assign done      = r_done;
  assign result    = r_result;
  assign dbg_state = r_state;

  // One multiply step: conditionally add the multiplicand to the upper half, then shift right.
  assign w_mul_sum  = {1'b0, r_acc[63:32]} + (r_acc[0] ? {1'b0, r_opa} : 33'd0);
  assign w_mul_next = {w_mul_sum, r_acc[31:1]};

`ifdef MULDIV_DIV_EN
  logic [31:0] r_opb;
  logic [32:0] w_div_shift;
  logic        w_div_ge;
  logic [31:0] w_div_sub;
  logic [63:0] w_div_next;

  // One restoring divide step. Bits [63:32] hold the remainder and bits [31:0] hold the dividend/quotient.
  // The true difference is always below 2^32, so a 32-bit subtract is exact.
  assign w_div_shift = {r_acc[63:32], r_acc[31]};
  assign w_div_ge    = (w_div_shift >= {1'b0, r_opb});
  assign w_div_sub   = w_div_shift[31:0] - r_opb;
  assign w_div_next  = w_div_ge ? {w_div_sub, r_acc[30:0], 1'b1}
                                : {w_div_shift[31:0], r_acc[30:0], 1'b0};
  assign w_step      = r_op[1] ? w_div_next : w_mul_next;
`else
  assign w_step      = w_mul_next;
`endif

  // Result of the 32nd step, selected by the latched op.
  always_comb begin
    w_final = 32'd0;
    case (r_op)
      2'b00:   w_final = w_mul_next[31:0];
      2'b01:   w_final = w_mul_next[63:32];
`ifdef MULDIV_DIV_EN
      2'b10:   w_final = w_div_next[31:0];
      default: w_final = w_div_next[63:32];
`else
      default: w_final = 32'd0;
`endif
    endcase
  end

  // Sequencer FSM. done/result are registered and are cleared every cycle unless DONE is being entered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_cnt    <= 6'd0;
      r_op     <= 2'b00;
      r_opa    <= 32'd0;
      r_acc    <= 64'd0;
      r_done   <= 1'b0;
      r_result <= 32'd0;
`ifdef MULDIV_DIV_EN
      r_opb    <= 32'd0;
`endif
    end else begin
      r_done   <= 1'b0;
      r_result <= 32'd0;
      case (r_state)
        S_IDLE, S_DONE: begin
          if (w_accept) begin
            r_op  <= op;
            r_opa <= src_a;
            r_cnt <= 6'd0;
`ifdef MULDIV_DIV_EN
            r_opb <= src_b;
`endif
            if (op[1]) begin
`ifdef MULDIV_DIV_EN
              if (src_b == 32'd0) begin
                // Divide by zero: quotient is all ones and remainder is the dividend.
                r_state  <= S_DONE;
                r_done   <= 1'b1;
                r_result <= op[0] ? src_a : 32'hFFFF_FFFF;
              end else begin
                r_state <= S_RUN;
                r_acc   <= {32'd0, src_a};
              end
`else
              r_state <= S_DONE;
              r_done  <= 1'b1;
`endif
            end else begin
              r_state <= S_RUN;
              r_acc   <= {32'd0, src_b};
            end
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_RUN: begin
          if (flush) begin
            r_state <= S_IDLE;
          end else begin
            r_acc <= w_step;
            if (r_cnt == 6'd31) begin
              r_state  <= S_DONE;
              r_done   <= 1'b1;
              r_result <= w_final;
            end else begin
              r_cnt <= r_cnt + 6'd1;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Testbench for muldiv_sequencer. It uses directed vectors and a scoreboard queue of expected results and done cycles.
module tb_muldiv_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        flush;
  logic        busy;
  logic        stall;
  logic        done;
  logic [31:0] result;
  logic [1:0]  dbg_state;

  int cyc = 0;
  int checks = 0;
  int failures = 0;
  logic [31:0] exp_q[$];
  int          exp_cyc_q[$];

  muldiv_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .src_a(src_a), .src_b(src_b),
    .flush(flush), .busy(busy), .stall(stall), .done(done), .result(result),
    .dbg_state(dbg_state)
  );

  // Clock and cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d actual=%0h required=%0h", name, cyc, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_to(input int c);
    while (cyc < c) step();
  endtask

  // Driver: the request is presented in the current cycle, and its expected response is queued.
  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input int lat, input bit push);
    op = o; src_a = a; src_b = b; start = 1'b1;
    #1;
    chk("stall_on_start", {31'd0, stall}, 32'd1);
    if (push) begin
      exp_q.push_back(exp);
      exp_cyc_q.push_back(cyc + lat);
    end
    step();
    start = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      step();
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain_timeout actual=%0d pending required=0", exp_q.size());
      exp_q.delete();
      exp_cyc_q.delete();
    end
    step();
  endtask

  // Monitor: compares every done pulse against the scoreboard, and checks that result is zero otherwise.
  always @(negedge clk) begin
    logic [31:0] e_res;
    int          e_cyc;
    if (reset === 1'b0) begin
      if (done === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_done cycle=%0d actual=%0h required=no_pulse", cyc, result);
        end else begin
          e_res = exp_q.pop_front();
          e_cyc = exp_cyc_q.pop_front();
          chk("result", result, e_res);
          chk("done_cycle", cyc, e_cyc);
        end
      end else begin
        chk("result_zero_when_idle", result, 32'd0);
      end
    end
  end

  initial begin
    int n;
    int bad;
    reset = 1'b1; start = 1'b0; flush = 1'b0; op = 2'b00; src_a = 32'd0; src_b = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_stall", {31'd0, stall}, 32'd0);
    chk("reset_done", {31'd0, done}, 32'd0);
    chk("reset_state", {30'd0, dbg_state}, 32'd0);
    reset = 1'b0;
    step();

    // MUL 7x6. stall is high from N through N+32, and the result arrives at N+33.
    n = cyc;
    issue(2'b00, 32'd7, 32'd6, 32'd42, 33, 1'b1);
    bad = 0;
    for (int i = 1; i <= 32; i++) begin
      if (stall !== 1'b1 || busy !== 1'b1) bad++;
      step();
    end
    chk("stall_run_cycles_bad", bad, 32'd0);
    chk("stall_in_done", {31'd0, stall}, 32'd0);
    chk("busy_in_done", {31'd0, busy}, 32'd0);
    drain();

    issue(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33, 1'b1);
    drain();
    issue(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 33, 1'b1);
    drain();
    issue(2'b01, 32'h8000_0000, 32'd6, 32'd3, 33, 1'b1);
    drain();

`ifdef MULDIV_DIV_EN
    issue(2'b10, 32'd100, 32'd7, 32'd14, 33, 1'b1);
    drain();
    issue(2'b11, 32'd100, 32'd7, 32'd2, 33, 1'b1);
    drain();
    issue(2'b10, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, 1'b1);
    drain();
    issue(2'b11, 32'd5, 32'd0, 32'd5, 1, 1'b1);
    drain();
    issue(2'b10, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 33, 1'b1);
    drain();
`else
    issue(2'b10, 32'd5, 32'd0, 32'd0, 1, 1'b1);
    drain();
    issue(2'b10, 32'd100, 32'd7, 32'd0, 1, 1'b1);
    drain();
    issue(2'b11, 32'd100, 32'd7, 32'd0, 1, 1'b1);
    drain();
`endif

    // A flush in mid-RUN aborts the operation, and no done pulse should ever appear.
    n = cyc;
    issue(2'b00, 32'd9, 32'd9, 32'd0, 0, 1'b0);
    wait_to(n + 10);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("flush_busy", {31'd0, busy}, 32'd0);
    chk("flush_stall", {31'd0, stall}, 32'd0);
    chk("flush_state", {30'd0, dbg_state}, 32'd0);
    repeat (40) step();

    // A start that arrives together with a flush is squashed.
    start = 1'b1; flush = 1'b1; op = 2'b00; src_a = 32'd3; src_b = 32'd4;
    #1;
    chk("start_flush_stall", {31'd0, stall}, 32'd0);
    step();
    start = 1'b0; flush = 1'b0;
    chk("start_flush_state", {30'd0, dbg_state}, 32'd0);
    repeat (40) step();

    // An asynchronous reset in mid-RUN clears the outputs before the next edge.
    n = cyc;
    issue(2'b00, 32'd5, 32'd5, 32'd0, 0, 1'b0);
    wait_to(n + 15);
    #2;
    reset = 1'b1;
    #1;
    chk("async_rst_busy", {31'd0, busy}, 32'd0);
    chk("async_rst_stall", {31'd0, stall}, 32'd0);
    chk("async_rst_done", {31'd0, done}, 32'd0);
    chk("async_rst_result", result, 32'd0);
    step();
    reset = 1'b0;
    issue(2'b00, 32'd3, 32'd3, 32'd9, 33, 1'b1);
    drain();

    // Back-to-back: the second start is issued in the DONE cycle of the first.
    n = cyc;
    issue(2'b00, 32'd11, 32'd13, 32'd143, 33, 1'b1);
    wait_to(n + 33);
    issue(2'b00, 32'd2, 32'd2, 32'd4, 33, 1'b1);
    drain();

    // A flush in DONE keeps the current pulse but cancels the new start.
    n = cyc;
    issue(2'b00, 32'd1, 32'd1, 32'd1, 33, 1'b1);
    wait_to(n + 33);
    start = 1'b1; flush = 1'b1; op = 2'b00; src_a = 32'd8; src_b = 32'd8;
    step();
    start = 1'b0; flush = 1'b0;
    chk("done_flush_busy", {31'd0, busy}, 32'd0);
    chk("done_flush_state", {30'd0, dbg_state}, 32'd0);
    repeat (40) step();
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
